// File: rtl/sample_loader_if.sv
// Host-side byte stream, response channel and playback read port of the sample loader.
// master = host/playback side, slave = the loader itself.
interface sample_loader_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned SLOT_W = 2
);
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic [7:0]        tx_data;
   logic              tx_send;
   logic              tx_ready;
   logic [SLOT_W-1:0] rd_slot;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;

   modport master (
      output rx_data, rx_ready, tx_ready, rd_slot, rd_addr,
      input  tx_data, tx_send, rd_data
   );

   modport slave (
      input  rx_data, rx_ready, tx_ready, rd_slot, rd_addr,
      output tx_data, tx_send, rd_data
   );
endinterface

// File: rtl/sample_loader.sv
// Receives framed sample uploads over UART, verifies them and stores the payload into
// one of NUM_SLOTS sample slots; answers ACK/NAK and offers a registered playback read port.
module sample_loader #(
   parameter int unsigned NUM_SLOTS  = 4,
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned SAMPLE_LEN = 4000,
   parameter int unsigned TIMEOUT    = 2000000
) (
   input  logic                 clk,
   input  logic                 rst,
   sample_loader_if.slave       bus,
   output logic [NUM_SLOTS-1:0] slot_valid,
   output logic [ADDR_W:0]      slot_len0,
   output logic [ADDR_W:0]      slot_len1,
   output logic [ADDR_W:0]      slot_len2,
   output logic [ADDR_W:0]      slot_len3,
   output logic                 busy
);
   localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
   localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
   localparam int unsigned MEM_W  = SLOT_W + ADDR_W;
   localparam logic [7:0]  SYNC   = 8'hA5;
   localparam logic [7:0]  ACK    = 8'h06;
   localparam logic [7:0]  NAK    = 8'h15;

   typedef enum logic [2:0] {
      StIdle, StSlot, StLenHi, StLenLo, StData, StChk, StResp
   } state_e;

   state_e               state_q, state_d;
   logic [SLOT_W-1:0]    slot_q, slot_d;
   logic [15:0]          len_q, len_d;
   logic [ADDR_W-1:0]    waddr_q, waddr_d;
   logic [7:0]           sum_q, sum_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic [NUM_SLOTS-1:0] valid_q, valid_d;
   logic [ADDR_W:0]      slen_q [NUM_SLOTS];
   logic [ADDR_W:0]      slen_d [NUM_SLOTS];
   logic [7:0]           rd_q;
   logic                 we;
   logic                 tx_send;
   logic                 in_frame;
   logic [15:0]          len_v;
   logic [7:0]           sum_v;

   logic [7:0] mem [2**MEM_W];

   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      len_d     = len_q;
      waddr_d   = waddr_q;
      sum_d     = sum_q;
      tx_data_d = tx_data_q;
      valid_d   = valid_q;
      slen_d    = slen_q;
      we        = 1'b0;
      tx_send   = 1'b0;
      len_v     = {len_q[15:8], bus.rx_data};
      sum_v     = sum_q + bus.rx_data;
      in_frame  = state_q inside {StSlot, StLenHi, StLenLo, StData, StChk};

      // Inter-byte idle counter; only runs while a frame is in progress.
      if (!in_frame || bus.rx_ready) tmo_d = '0;
      else                           tmo_d = tmo_q + TMO_W'(1);

      unique case (state_q)
         StIdle: begin
            if (bus.rx_ready && bus.rx_data == SYNC) state_d = StSlot;
         end
         StSlot: begin
            if (bus.rx_ready) begin
               if (32'(bus.rx_data) >= NUM_SLOTS) begin
                  tx_data_d = NAK;
                  state_d   = StResp;
               end else begin
                  slot_d                        = bus.rx_data[SLOT_W-1:0];
                  valid_d[bus.rx_data[SLOT_W-1:0]] = 1'b0;
                  sum_d                         = bus.rx_data;
                  state_d                       = StLenHi;
               end
            end
         end
         StLenHi: begin
            if (bus.rx_ready) begin
               len_d   = {bus.rx_data, len_q[7:0]};
               sum_d   = sum_v;
               state_d = StLenLo;
            end
         end
         StLenLo: begin
            if (bus.rx_ready) begin
               len_d = len_v;
               sum_d = sum_v;
               if (len_v == '0 || 32'(len_v) > SAMPLE_LEN) begin
                  tx_data_d = NAK;
                  state_d   = StResp;
               end else begin
                  waddr_d = '0;
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (bus.rx_ready) begin
               we      = 1'b1;
               waddr_d = waddr_q + ADDR_W'(1);
               sum_d   = sum_v;
               if (16'(waddr_q) + 16'd1 == len_q) state_d = StChk;
            end
         end
         StChk: begin
            if (bus.rx_ready) begin
               sum_d = sum_v;
               if (sum_v == 8'h00) begin
                  valid_d[slot_q] = 1'b1;
                  slen_d[slot_q]  = len_q[ADDR_W:0];
                  tx_data_d       = ACK;
               end else begin
                  tx_data_d = NAK;
               end
               state_d = StResp;
            end
         end
         StResp: begin
            if (bus.tx_ready) begin
               tx_send = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // A byte arriving on the expiry cycle wins over the timeout.
      if (in_frame && !bus.rx_ready && tmo_q == TMO_W'(TIMEOUT - 1)) begin
         tx_data_d = NAK;
         state_d   = StResp;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         slot_q    <= '0;
         len_q     <= '0;
         waddr_q   <= '0;
         sum_q     <= '0;
         tmo_q     <= '0;
         tx_data_q <= '0;
         valid_q   <= '0;
         slen_q    <= '{default: '0};
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         len_q     <= len_d;
         waddr_q   <= waddr_d;
         sum_q     <= sum_d;
         tmo_q     <= tmo_d;
         tx_data_q <= tx_data_d;
         valid_q   <= valid_d;
         slen_q    <= slen_d;
         rd_q      <= mem[{bus.rd_slot, bus.rd_addr}];
      end
   end

   // Sample RAM is deliberately not reset; slot_valid gates its use.
   always_ff @(posedge clk) begin
      if (we) mem[{slot_q, waddr_q}] <= bus.rx_data;
   end

   assign bus.tx_data = tx_data_q;
   assign bus.tx_send = tx_send;
   assign bus.rd_data = rd_q;
   assign slot_valid  = valid_q;
   assign slot_len0   = slen_q[0];
   assign slot_len1   = slen_q[1];
   assign slot_len2   = slen_q[2];
   assign slot_len3   = slen_q[3];
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_sample_loader.sv
// Self-checking bench for sample_loader: table-driven frames with a response scoreboard,
// plus hand-written timeout, backpressure and mid-frame reset sequences.
module tb_sample_loader;
   localparam int unsigned TMO = 300;
   localparam logic [7:0]  ACK = 8'h06;
   localparam logic [7:0]  NAK = 8'h15;

   typedef struct {
      logic [7:0]  slot;
      logic [15:0] len;
      logic [7:0]  base;
      logic [7:0]  step;
      logic [7:0]  chk_err;
      int          stop;   // 0 full frame, 1 stop after slot, 2 stop after LEN_LO
      logic [7:0]  resp;
      logic [3:0]  valid;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  slot_valid;
   logic [12:0] slot_len0, slot_len1, slot_len2, slot_len3;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;
   int tx_cnt   = 0;
   logic [7:0] exp_q [$];
   vec_t vecs [8];

   sample_loader_if #(.ADDR_W(12), .SLOT_W(2)) bus ();

   sample_loader #(
      .NUM_SLOTS(4), .ADDR_W(12), .SAMPLE_LEN(4000), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .slot_valid(slot_valid),
      .slot_len0(slot_len0), .slot_len1(slot_len1),
      .slot_len2(slot_len2), .slot_len3(slot_len3),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Response scoreboard: every tx_send must match the oldest pushed expectation.
   always @(negedge clk) begin
      if (bus.tx_send === 1'b1) begin
         tx_cnt++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_tx: got %0h expected no response", bus.tx_data);
         end else begin
            chk("resp_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
         end
      end
   end

   function automatic logic [12:0] len_of(input logic [1:0] s);
      case (s)
         2'd0:    return slot_len0;
         2'd1:    return slot_len1;
         2'd2:    return slot_len2;
         default: return slot_len3;
      endcase
   endfunction

   function automatic logic [7:0] pay(input vec_t v, input int i);
      return v.base + v.step * 8'(i);
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #2;
      bus.rx_data  = b;
      bus.rx_ready = 1'b1;
      @(posedge clk); #2;
      bus.rx_ready = 1'b0;
   endtask

   task automatic send_vec(input vec_t v);
      logic [7:0] sum;
      exp_q.push_back(v.resp);
      send_byte(8'hA5);
      send_byte(v.slot);
      if (v.stop == 1) return;
      send_byte(v.len[15:8]);
      send_byte(v.len[7:0]);
      if (v.stop == 2) return;
      sum = v.slot + v.len[15:8] + v.len[7:0];
      for (int i = 0; i < int'(v.len); i++) begin
         send_byte(pay(v, i));
         sum = sum + pay(v, i);
      end
      send_byte((8'h00 - sum) + v.chk_err);
   endtask

   task automatic wait_resp(input string name, input int budget, input int start);
      logic found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (tx_cnt != start) begin
            found = 1'b1;
            break;
         end
      end
      chk(name, 32'(found), 32'd1);
   endtask

   task automatic rd_check(input string name, input logic [1:0] s, input logic [11:0] a,
                           input logic [7:0] e);
      @(posedge clk); #2;
      bus.rd_slot = s;
      bus.rd_addr = a;
      @(posedge clk);
      @(negedge clk);
      chk(name, 32'(bus.rd_data), 32'(e));
   endtask

   task automatic check_after(input vec_t v);
      @(posedge clk); #2;
      chk("busy_idle", 32'(busy), 32'd0);
      chk("slot_valid", 32'(slot_valid), 32'(v.valid));
      if (v.resp == ACK) begin
         chk("slot_len", 32'(len_of(v.slot[1:0])), 32'(v.len));
         for (int i = 0; i < int'(v.len); i++)
            rd_check("readback", v.slot[1:0], 12'(i), pay(v, i));
      end
   endtask

   initial begin
      int start;
      int lat;
      vec_t v;

      vecs[0] = '{8'h01, 16'd3,      8'h10, 8'h10, 8'h00, 0, ACK, 4'b0010};
      vecs[1] = '{8'h01, 16'd3,      8'h10, 8'h10, 8'h01, 0, NAK, 4'b0000};
      vecs[2] = '{8'h04, 16'd0,      8'h00, 8'h00, 8'h00, 1, NAK, 4'b0000};
      vecs[3] = '{8'h00, 16'h0FA1,   8'h00, 8'h00, 8'h00, 2, NAK, 4'b0000};
      vecs[4] = '{8'h03, 16'd5,      8'h33, 8'h07, 8'h00, 0, ACK, 4'b1000};
      vecs[5] = '{8'h01, 16'd3,      8'hA0, 8'h01, 8'h00, 0, ACK, 4'b1010};
      vecs[6] = '{8'h00, 16'd1,      8'h5A, 8'h00, 8'h00, 0, ACK, 4'b1011};
      vecs[7] = '{8'h02, 16'd0,      8'h00, 8'h00, 8'h00, 2, NAK, 4'b1011};

      bus.rx_data  = '0;
      bus.rx_ready = 1'b0;
      bus.tx_ready = 1'b1;
      bus.rd_slot  = '0;
      bus.rd_addr  = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
      chk("rst_tx_send", 32'(bus.tx_send), 32'd0);
      chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_slot_valid", 32'(slot_valid), 32'd0);
      chk("rst_slot_len3", 32'(slot_len3), 32'd0);
      rst = 1'b1;

      // Garbage outside a frame is silently ignored.
      start = tx_cnt;
      send_byte(8'h00);
      chk("garbage_busy0", 32'(busy), 32'd0);
      send_byte(8'hFF);
      chk("garbage_busy1", 32'(busy), 32'd0);
      repeat (5) @(posedge clk);
      chk("garbage_no_tx", 32'(tx_cnt), 32'(start));

      foreach (vecs[k]) begin
         start = tx_cnt;
         send_vec(vecs[k]);
         wait_resp($sformatf("resp_vec%0d", k), 3, start);
         check_after(vecs[k]);
      end

      // Timeout after A5 02 00, then a normal load of slot 2.
      start = tx_cnt;
      exp_q.push_back(NAK);
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h00);
      lat = 0;
      for (int i = 1; i <= 2 * TMO; i++) begin
         @(posedge clk);
         if (tx_cnt != start) begin
            lat = i;
            break;
         end
      end
      chk("timeout_latency", 32'(lat), 32'(TMO + 1));
      v = '{8'h02, 16'd2, 8'h11, 8'h11, 8'h00, 0, ACK, 4'b1111};
      start = tx_cnt;
      send_vec(v);
      wait_resp("resp_after_timeout", 3, start);
      check_after(v);

      // Backpressure: response held off, bytes during the wait are dropped.
      v = '{8'h03, 16'd2, 8'hC1, 8'h01, 8'h00, 0, ACK, 4'b1111};
      bus.tx_ready = 1'b0;
      start = tx_cnt;
      send_vec(v);
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'h01);
      repeat (42) @(posedge clk);
      chk("bp_no_tx_while_blocked", 32'(tx_cnt), 32'(start));
      chk("bp_busy_while_blocked", 32'(busy), 32'd1);
      #2;
      bus.tx_ready = 1'b1;
      @(negedge clk);
      chk("bp_tx_send_first_cycle", 32'(bus.tx_send), 32'd1);
      @(posedge clk);
      check_after(v);

      // Reset during the second payload byte.
      start = tx_cnt;
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h04);
      send_byte(8'h01);
      @(posedge clk); #2;
      bus.rx_data  = 8'h02;
      bus.rx_ready = 1'b1;
      rst = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_slot_valid", 32'(slot_valid), 32'd0);
      @(posedge clk); #2;
      bus.rx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      repeat (20) @(posedge clk);
      #2;
      chk("midrst_no_tx", 32'(tx_cnt), 32'(start));
      chk("midrst_busy_after", 32'(busy), 32'd0);
      chk("midrst_slot_len1", 32'(slot_len1), 32'd0);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
